// File: rtl/dmem_port_arbiter_if.sv
// Debug requester handshake into the data-memory port arbiter.
// req/addr/we/wdata are held by the master until the one-cycle ack.
interface dmem_port_arbiter_if;
  logic        dbg_req;
  logic        dbg_we;
  logic [15:0] dbg_addr;
  logic [7:0]  dbg_wdata;
  logic        dbg_ack;
  logic [7:0]  dbg_rdata;

  modport master (
    output dbg_req,
    output dbg_we,
    output dbg_addr,
    output dbg_wdata,
    input  dbg_ack,
    input  dbg_rdata
  );

  modport slave (
    input  dbg_req,
    input  dbg_we,
    input  dbg_addr,
    input  dbg_wdata,
    output dbg_ack,
    output dbg_rdata
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Shares single-ported data memory between the CPU load/store path
// and a debug requester; CPU owns the port except in one-cycle debug slots.
module dmem_port_arbiter #(
  parameter int MAX_WAIT = 16,
  parameter int WAIT_W   = 5
) (
  input  logic        clk100,
  input  logic        reset,
  input  logic        cpu_rd_en,
  input  logic [15:0] cpu_rd_addr,
  input  logic        cpu_wr_en,
  input  logic [15:0] cpu_wr_addr,
  input  logic [7:0]  cpu_wr_data,
  output logic        cpu_stall,
  output logic [7:0]  cpu_rdata,
  dmem_port_arbiter_if.slave dbg,
  output logic [7:0]  force_cnt,
  output logic [15:0] dmem_rd_addr,
  output logic [15:0] dmem_wr_addr,
  output logic [7:0]  dmem_wr_data,
  output logic        dmem_wr_en,
  input  logic [7:0]  dmem_dout
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [7:0]        force_q, force_d;
  logic [7:0]        rdata_q, rdata_d;
  logic              cpu_busy;
  logic              at_max;

  assign cpu_busy = cpu_rd_en | cpu_wr_en;
  assign at_max   = (wait_q == WAIT_W'(MAX_WAIT));

  always_ff @(posedge clk100 or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      wait_q  <= '0;
      force_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      force_q <= force_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    force_d      = force_q;
    rdata_d      = rdata_q;
    cpu_stall    = 1'b0;
    dbg.dbg_ack  = 1'b0;
    dmem_rd_addr = cpu_rd_addr;
    dmem_wr_addr = cpu_wr_addr;
    dmem_wr_data = cpu_wr_data;
    dmem_wr_en   = cpu_wr_en;
    unique case (state_q)
      IDLE: begin
        if (dbg.dbg_req && (!cpu_busy || at_max)) begin
          state_d = GRANT;
          wait_d  = '0;
          // a busy CPU here means the wait bound expired
          if (cpu_busy && force_q != 8'hFF)
            force_d = force_q + 8'd1;
        end else if (dbg.dbg_req && cpu_busy) begin
          wait_d = wait_q + WAIT_W'(1);
        end else begin
          wait_d = '0;
        end
      end
      GRANT: begin
        cpu_stall    = 1'b1;
        dmem_rd_addr = dbg.dbg_addr;
        dmem_wr_addr = dbg.dbg_addr;
        dmem_wr_data = dbg.dbg_wdata;
        dmem_wr_en   = dbg.dbg_we;
        state_d      = DONE;
      end
      DONE: begin
        dbg.dbg_ack = 1'b1;
        if (!dbg.dbg_we)
          rdata_d = dmem_dout;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign dbg.dbg_rdata = (state_q == DONE && !dbg.dbg_we)
                       ? dmem_dout : rdata_q;
  assign cpu_rdata     = dmem_dout;
  assign force_cnt     = force_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: vector table, forced-grant and reset
// sequences, then random traffic against a transaction-level model.
module tb_dmem_port_arbiter;
  localparam int MW = 16;

  logic        clk100 = 1'b0;
  logic        reset  = 1'b0;
  logic        cpu_rd_en, cpu_wr_en;
  logic [15:0] cpu_rd_addr, cpu_wr_addr;
  logic [7:0]  cpu_wr_data;
  logic        cpu_stall;
  logic [7:0]  cpu_rdata;
  logic [7:0]  force_cnt;
  logic [15:0] dmem_rd_addr, dmem_wr_addr;
  logic [7:0]  dmem_wr_data;
  logic        dmem_wr_en;
  logic [7:0]  dmem_dout = 8'h00;
  logic [7:0]  mem [0:65535];

  dmem_port_arbiter_if dbg ();

  dmem_port_arbiter #(.MAX_WAIT(MW), .WAIT_W(5)) dut (
    .clk100      (clk100),
    .reset       (reset),
    .cpu_rd_en   (cpu_rd_en),
    .cpu_rd_addr (cpu_rd_addr),
    .cpu_wr_en   (cpu_wr_en),
    .cpu_wr_addr (cpu_wr_addr),
    .cpu_wr_data (cpu_wr_data),
    .cpu_stall   (cpu_stall),
    .cpu_rdata   (cpu_rdata),
    .dbg         (dbg),
    .force_cnt   (force_cnt),
    .dmem_rd_addr(dmem_rd_addr),
    .dmem_wr_addr(dmem_wr_addr),
    .dmem_wr_data(dmem_wr_data),
    .dmem_wr_en  (dmem_wr_en),
    .dmem_dout   (dmem_dout)
  );

  always #5 clk100 = ~clk100;

  always @(posedge clk100) begin
    if (dmem_wr_en) mem[dmem_wr_addr] <= dmem_wr_data;
    dmem_dout <= mem[dmem_rd_addr];
  end

  // Transaction model: slot 0 = none, 1 = debug owns port, 2 = ack cycle
  int          m_slot, m_wait, m_force;
  logic [7:0]  m_hold, m_val;
  logic [7:0]  ref_mem [int];
  logic        last_ack;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [7:0] ref_rd(int a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic model_check();
    logic g;
    @(negedge clk100);
    if (!reset) begin
      m_slot = 0; m_wait = 0; m_force = 0; m_hold = 8'h00;
    end
    g = (m_slot == 1);
    chk("stall", 32'(cpu_stall), 32'(g));
    chk("ack", 32'(dbg.dbg_ack), 32'(m_slot == 2));
    chk("rd_addr", 32'(dmem_rd_addr), 32'(g ? dbg.dbg_addr : cpu_rd_addr));
    chk("wr_addr", 32'(dmem_wr_addr), 32'(g ? dbg.dbg_addr : cpu_wr_addr));
    chk("wr_data", 32'(dmem_wr_data), 32'(g ? dbg.dbg_wdata : cpu_wr_data));
    chk("wr_en", 32'(dmem_wr_en), 32'(g ? dbg.dbg_we : cpu_wr_en));
    chk("dbg_rdata", 32'(dbg.dbg_rdata),
        32'((m_slot == 2 && !dbg.dbg_we) ? m_val : m_hold));
    chk("force_cnt", 32'(force_cnt), 32'(m_force));
    chk("cpu_rdata", 32'(cpu_rdata), 32'(dmem_dout));
    last_ack = dbg.dbg_ack;
  endtask

  task automatic cpu_write();
    if (cpu_wr_en) ref_mem[int'(cpu_wr_addr)] = cpu_wr_data;
  endtask

  task automatic model_adv();
    logic busy;
    busy = cpu_rd_en | cpu_wr_en;
    if (!reset) begin
      cpu_write();
    end else if (m_slot == 1) begin
      if (dbg.dbg_we) ref_mem[int'(dbg.dbg_addr)] = dbg.dbg_wdata;
      else m_val = ref_rd(int'(dbg.dbg_addr));
      m_slot = 2;
    end else if (m_slot == 2) begin
      if (!dbg.dbg_we) m_hold = m_val;
      cpu_write();
      m_slot = 0;
    end else begin
      cpu_write();
      if (dbg.dbg_req && (!busy || m_wait == MW)) begin
        if (busy && m_force < 255) m_force++;
        m_wait = 0;
        m_slot = 1;
      end else if (dbg.dbg_req && busy) begin
        m_wait++;
      end else begin
        m_wait = 0;
      end
    end
    @(posedge clk100);
    #1;
  endtask

  typedef struct {
    logic        rd, wr;
    logic [15:0] caddr;
    logic [7:0]  cdata;
    logic        req, we;
    logic [15:0] daddr;
    logic [7:0]  dwdata;
    logic        e_stall, e_ack, e_wen;
    logic [7:0]  e_rdata;
  } vec_t;

  vec_t tv [16];

  initial begin
    int n;
    tv[0]  = '{0, 0, 16'h0000, 8'h00, 1, 1, 16'h0040, 8'hA5, 0, 0, 0, 8'h00};
    tv[1]  = '{0, 0, 16'h0000, 8'h00, 1, 1, 16'h0040, 8'hA5, 1, 0, 1, 8'h00};
    tv[2]  = '{0, 0, 16'h0000, 8'h00, 1, 1, 16'h0040, 8'hA5, 0, 1, 0, 8'h00};
    tv[3]  = '{0, 0, 16'h0000, 8'h00, 0, 1, 16'h0040, 8'hA5, 0, 0, 0, 8'h00};
    tv[4]  = '{0, 0, 16'h0000, 8'h00, 1, 0, 16'h0040, 8'h00, 0, 0, 0, 8'h00};
    tv[5]  = '{0, 0, 16'h0000, 8'h00, 1, 0, 16'h0040, 8'h00, 1, 0, 0, 8'h00};
    tv[6]  = '{0, 0, 16'h0000, 8'h00, 1, 0, 16'h0040, 8'h00, 0, 1, 0, 8'hA5};
    tv[7]  = '{0, 0, 16'h0000, 8'h00, 0, 0, 16'h0040, 8'h00, 0, 0, 0, 8'hA5};
    tv[8]  = '{0, 0, 16'h0000, 8'h00, 1, 0, 16'h0010, 8'h00, 0, 0, 0, 8'hA5};
    tv[9]  = '{0, 1, 16'h0010, 8'h3C, 1, 0, 16'h0010, 8'h00, 1, 0, 0, 8'hA5};
    tv[10] = '{0, 1, 16'h0010, 8'h3C, 1, 0, 16'h0010, 8'h00, 0, 1, 1, 8'h00};
    tv[11] = '{0, 0, 16'h0010, 8'h00, 0, 0, 16'h0010, 8'h00, 0, 0, 0, 8'h00};
    tv[12] = '{0, 0, 16'h0000, 8'h00, 1, 0, 16'h0010, 8'h00, 0, 0, 0, 8'h00};
    tv[13] = '{0, 0, 16'h0000, 8'h00, 1, 0, 16'h0010, 8'h00, 1, 0, 0, 8'h00};
    tv[14] = '{0, 0, 16'h0000, 8'h00, 1, 0, 16'h0010, 8'h00, 0, 1, 0, 8'h3C};
    tv[15] = '{0, 0, 16'h0000, 8'h00, 0, 0, 16'h0010, 8'h00, 0, 0, 0, 8'h3C};

    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    m_slot = 0; m_wait = 0; m_force = 0;
    m_hold = 8'h00; m_val = 8'h00; last_ack = 1'b0;

    // reset held with a pending debug request
    cpu_rd_en = 1'b1; cpu_rd_addr = 16'h1234;
    cpu_wr_en = 1'b0; cpu_wr_addr = 16'h2345; cpu_wr_data = 8'h11;
    dbg.dbg_req = 1'b1; dbg.dbg_we = 1'b1;
    dbg.dbg_addr = 16'h0040; dbg.dbg_wdata = 8'h5A;
    @(posedge clk100);
    #1;
    repeat (3) begin
      model_check();
      model_adv();
    end
    reset = 1'b1;
    dbg.dbg_req = 1'b0;
    cpu_rd_en = 1'b0;

    // idle write, idle read, CPU store during grant
    for (int i = 0; i < 16; i++) begin
      cpu_rd_en = tv[i].rd;     cpu_rd_addr = tv[i].caddr;
      cpu_wr_en = tv[i].wr;     cpu_wr_addr = tv[i].caddr;
      cpu_wr_data = tv[i].cdata;
      dbg.dbg_req = tv[i].req;  dbg.dbg_we = tv[i].we;
      dbg.dbg_addr = tv[i].daddr; dbg.dbg_wdata = tv[i].dwdata;
      model_check();
      chk($sformatf("tv%0d_stall", i), 32'(cpu_stall), 32'(tv[i].e_stall));
      chk($sformatf("tv%0d_ack", i), 32'(dbg.dbg_ack), 32'(tv[i].e_ack));
      chk($sformatf("tv%0d_wen", i), 32'(dmem_wr_en), 32'(tv[i].e_wen));
      chk($sformatf("tv%0d_rdata", i), 32'(dbg.dbg_rdata), 32'(tv[i].e_rdata));
      chk($sformatf("tv%0d_force", i), 32'(force_cnt), 32'h0);
      model_adv();
    end
    chk("mem_40", 32'(mem[16'h0040]), 32'hA5);
    chk("mem_10", 32'(mem[16'h0010]), 32'h3C);

    // forced grants under a permanently busy CPU
    cpu_wr_en = 1'b0;
    for (int k = 0; k < 300; k++) begin
      cpu_rd_en = 1'b1;
      cpu_rd_addr = 16'($urandom_range(15, 0));
      dbg.dbg_req = 1'b1; dbg.dbg_we = 1'b0; dbg.dbg_addr = 16'h0040;
      n = 0;
      model_check();
      while (!cpu_stall && n <= 100) begin
        model_adv();
        n++;
        model_check();
      end
      chk("force_wait", 32'(n), 32'(MW + 1));
      model_adv();
      model_check();
      chk("force_ack", 32'(dbg.dbg_ack), 32'h1);
      chk("force_rdata", 32'(dbg.dbg_rdata), 32'hA5);
      if (k == 0) chk("force_first", 32'(force_cnt), 32'h1);
      model_adv();
      dbg.dbg_req = 1'b0;
      model_check();
      model_adv();
    end
    chk("force_sat", 32'(force_cnt), 32'd255);

    // reset during a debug write slot
    cpu_rd_en = 1'b0; cpu_wr_en = 1'b0;
    dbg.dbg_req = 1'b1; dbg.dbg_we = 1'b1;
    dbg.dbg_addr = 16'h0080; dbg.dbg_wdata = 8'h77;
    model_check();
    model_adv();
    chk("rst_in_grant", 32'(cpu_stall), 32'h1);
    reset = 1'b0;
    repeat (3) begin
      model_check();
      chk("rst_no_ack", 32'(dbg.dbg_ack), 32'h0);
      model_adv();
    end
    reset = 1'b1;
    dbg.dbg_req = 1'b0;
    model_check();
    chk("rst_no_write", 32'(mem[16'h0080]), 32'h00);
    model_adv();

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      cpu_rd_en = ($urandom_range(4, 0) != 0);
      cpu_wr_en = ($urandom_range(3, 0) == 0);
      cpu_rd_addr = 16'($urandom_range(15, 0));
      cpu_wr_addr = 16'($urandom_range(15, 0));
      cpu_wr_data = 8'($urandom);
      if (!dbg.dbg_req || last_ack) begin
        dbg.dbg_req = ($urandom_range(2, 0) != 0);
        dbg.dbg_we = 1'($urandom_range(1, 0));
        dbg.dbg_addr = 16'($urandom_range(15, 0));
        dbg.dbg_wdata = 8'($urandom);
      end
      reset = !(c >= 2000 && c < 2002);
      model_check();
      model_adv();
    end
    reset = 1'b1;
    for (int a = 0; a < 16; a++)
      chk($sformatf("mem_%0d", a), 32'(mem[a]), 32'(ref_rd(a)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
